// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, instruction field positions, opcode class
// decode and the operand sequencer state encoding.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_RED    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    CLS_REG  = 2'd0,
    CLS_IMM  = 2'd1,
    CLS_CTRL = 2'd2
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_A  = 2'd1,
    ST_RD_B  = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    case (op[3:2])
      2'b00, 2'b01: cls = CLS_REG;
      2'b10:        cls = CLS_IMM;
      default:      cls = CLS_CTRL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rd_lat_cnt.sv
// Read-latency counter shared by both operand reads: counts 0..RD_LAT while a
// read state is active and flags the cycle in which rf_rdata is valid.
module rd_lat_cnt #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam logic [1:0] LAST = 2'(RD_LAT);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  assign done = (cnt_q == LAST);

  // Next count: restart on a new read, wrap after the capture cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 2'd0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else begin
      cnt_d = 2'd0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/operand_seq_ctrl.sv
// Operand-fetch sequencer for the WISC execute stage: serialises operand reads
// over the single RF read port and hands a valid/ready bundle to the ALU.
module operand_seq_ctrl
  import wisc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_vld,
  input  logic [15:0]       instr,
  output logic              instr_rdy,
  output logic              rf_re,
  output logic [3:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              alu_vld,
  input  logic              alu_rdy,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] src0,
  output logic [DATA_W-1:0] src1,
  output logic [7:0]        imm,
  output logic              src_sel,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [3:0]          b_addr_q, b_addr_d;
  logic                need_b_q, need_b_d;
  logic [DATA_W-1:0]   src0_q, src0_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [7:0]          imm_q, imm_d;
  logic                src_sel_q, src_sel_d;
  logic                alu_vld_q, alu_vld_d;
  logic                rf_re_q, rf_re_d;
  logic [3:0]          rf_addr_q, rf_addr_d;
  logic                instr_rdy_q, instr_rdy_d;
  logic                halted_q, halted_d;

  logic [3:0]          in_op, in_ra, in_rs, in_rt;
  op_class_e           in_cls;
  logic [3:0]          in_a_addr;
  logic                in_need_a, in_need_b;
  logic                cnt_start, cnt_run, cnt_done;

  assign in_op  = instr[OP_MSB:OP_LSB];
  assign in_ra  = instr[RA_MSB:RA_LSB];
  assign in_rs  = instr[RS_MSB:RS_LSB];
  assign in_rt  = instr[RT_MSB:RT_LSB];
  assign in_cls = op_class(in_op);

  assign cnt_run = (state_q == ST_RD_A) || (state_q == ST_RD_B);

  rd_lat_cnt #(.RD_LAT(RD_LAT)) u_rd_lat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cnt_start),
    .run   (cnt_run),
    .done  (cnt_done)
  );

  // Decode which operand reads the incoming instruction needs; R0 may be skipped.
  always_comb begin
    in_a_addr = 4'd0;
    in_need_a = 1'b0;
    in_need_b = 1'b0;
    case (in_cls)
      CLS_REG: begin
        in_a_addr = in_rs;
        in_need_a = !(ZERO_R0 && (in_rs == 4'd0));
        in_need_b = !(ZERO_R0 && (in_rt == 4'd0));
      end
      CLS_IMM: begin
        in_a_addr = in_ra;
        in_need_a = !(ZERO_R0 && (in_ra == 4'd0));
        in_need_b = 1'b0;
      end
      default: begin
        in_a_addr = 4'd0;
        in_need_a = 1'b0;
        in_need_b = 1'b0;
      end
    endcase
  end

  // Sequencer next state; rf_re/rf_addr are one-cycle pulses launched on entry to a read.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    b_addr_d  = b_addr_q;
    need_b_d  = need_b_q;
    src0_d    = src0_q;
    src1_d    = src1_q;
    imm_d     = imm_q;
    src_sel_d = src_sel_q;
    alu_vld_d = alu_vld_q;
    halted_d  = halted_q;
    rf_re_d   = 1'b0;
    rf_addr_d = 4'd0;
    cnt_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_vld && instr_rdy_q) begin
          op_d      = in_op;
          imm_d     = instr[IMM_MSB:IMM_LSB];
          src_sel_d = (in_cls != CLS_IMM);
          src0_d    = '0;
          src1_d    = '0;
          need_b_d  = in_need_b;
          b_addr_d  = in_rt;
          cnt_start = 1'b1;
          if (in_need_a) begin
            state_d   = ST_RD_A;
            rf_re_d   = 1'b1;
            rf_addr_d = in_a_addr;
          end else if (in_need_b) begin
            state_d   = ST_RD_B;
            rf_re_d   = 1'b1;
            rf_addr_d = in_rt;
          end else begin
            state_d   = ST_ISSUE;
            alu_vld_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_A: begin
        if (cnt_done) begin
          src0_d = rf_rdata;
          if (need_b_q) begin
            state_d   = ST_RD_B;
            rf_re_d   = 1'b1;
            rf_addr_d = b_addr_q;
            cnt_start = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            alu_vld_d = 1'b1;
          end
        end else begin
          state_d = ST_RD_A;
        end
      end
      ST_RD_B: begin
        if (cnt_done) begin
          src1_d    = rf_rdata;
          state_d   = ST_ISSUE;
          alu_vld_d = 1'b1;
        end else begin
          state_d = ST_RD_B;
        end
      end
      ST_ISSUE: begin
        if (alu_rdy) begin
          state_d   = ST_IDLE;
          alu_vld_d = 1'b0;
          if (op_q == OP_HLT) begin
            halted_d = 1'b1;
          end else begin
            halted_d = halted_q;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        alu_vld_d = 1'b0;
      end
    endcase
    instr_rdy_d = (state_d == ST_IDLE) && !halted_d;
  end

  // Single state/output register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 4'd0;
      b_addr_q    <= 4'd0;
      need_b_q    <= 1'b0;
      src0_q      <= '0;
      src1_q      <= '0;
      imm_q       <= 8'd0;
      src_sel_q   <= 1'b0;
      alu_vld_q   <= 1'b0;
      rf_re_q     <= 1'b0;
      rf_addr_q   <= 4'd0;
      instr_rdy_q <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      b_addr_q    <= b_addr_d;
      need_b_q    <= need_b_d;
      src0_q      <= src0_d;
      src1_q      <= src1_d;
      imm_q       <= imm_d;
      src_sel_q   <= src_sel_d;
      alu_vld_q   <= alu_vld_d;
      rf_re_q     <= rf_re_d;
      rf_addr_q   <= rf_addr_d;
      instr_rdy_q <= instr_rdy_d;
      halted_q    <= halted_d;
    end
  end

  assign instr_rdy = instr_rdy_q;
  assign rf_re     = rf_re_q;
  assign rf_addr   = rf_addr_q;
  assign alu_vld   = alu_vld_q;
  assign alu_op    = op_q;
  assign src0      = src0_q;
  assign src1      = src1_q;
  assign imm       = imm_q;
  assign src_sel   = src_sel_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Randomised self-checking bench for operand_seq_ctrl against a cycle-count
// reference model; a second instance covers RD_LAT=3.
module tb_operand_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rf [16];

  logic        instr_vld1, instr_rdy1, rf_re1, alu_vld1, alu_rdy1, src_sel1, halted1;
  logic [15:0] instr1, rf_rdata1, src0_1, src1_1;
  logic [3:0]  rf_addr1, alu_op1;
  logic [7:0]  imm1;

  logic        instr_vld3, instr_rdy3, rf_re3, alu_vld3, alu_rdy3, src_sel3, halted3;
  logic [15:0] instr3, rf_rdata3, src0_3, src1_3;
  logic [3:0]  rf_addr3, alu_op3;
  logic [7:0]  imm3;

  operand_seq_ctrl #(.DATA_W(16), .RD_LAT(1), .ZERO_R0(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_vld(instr_vld1), .instr(instr1), .instr_rdy(instr_rdy1),
    .rf_re(rf_re1), .rf_addr(rf_addr1), .rf_rdata(rf_rdata1), .alu_vld(alu_vld1),
    .alu_rdy(alu_rdy1), .alu_op(alu_op1), .src0(src0_1), .src1(src1_1), .imm(imm1),
    .src_sel(src_sel1), .halted(halted1));

  operand_seq_ctrl #(.DATA_W(16), .RD_LAT(3), .ZERO_R0(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_vld(instr_vld3), .instr(instr3), .instr_rdy(instr_rdy3),
    .rf_re(rf_re3), .rf_addr(rf_addr3), .rf_rdata(rf_rdata3), .alu_vld(alu_vld3),
    .alu_rdy(alu_rdy3), .alu_op(alu_op3), .src0(src0_3), .src1(src1_3), .imm(imm3),
    .src_sel(src_sel3), .halted(halted3));

  // Register-file models: data valid exactly RD_LAT cycles after rf_re, junk otherwise.
  logic [3:0] p1_addr;
  logic       p1_re;
  logic [3:0] p3_addr [3];
  logic [2:0] p3_re;
  always @(posedge clk) begin
    p1_addr    <= rf_addr1;
    p1_re      <= rf_re1;
    p3_re      <= {p3_re[1:0], rf_re3};
    p3_addr[0] <= rf_addr3;
    p3_addr[1] <= p3_addr[0];
    p3_addr[2] <= p3_addr[1];
  end
  assign rf_rdata1 = (p1_re === 1'b1) ? rf[p1_addr] : 16'hBEEF;
  assign rf_rdata3 = (p3_re[2] === 1'b1) ? rf[p3_addr[2]] : 16'hBEEF;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Observations gathered by run1 for one instruction on dut1.
  int          nre, vld_cyc, stable_bad, addr_bad;
  logic [3:0]  re_addr [4];
  int          re_cyc [4];
  logic [15:0] b_src0, b_src1;
  logic [7:0]  b_imm;
  logic        b_sel, post_vld, post_rdy, post_halt;
  logic [3:0]  b_op;

  // Reference: operand reads, expected bundle and alu_vld cycle from the ISA rules.
  function automatic void model(input logic [15:0] ins, input int lat, output int nrd,
                                output logic [3:0] ad0, output logic [3:0] ad1,
                                output logic [15:0] e0, output logic [15:0] e1,
                                output logic esel, output int evld);
    logic [3:0] op, ra, rs, rt;
    op = ins[15:12]; ra = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    nrd = 0; ad0 = 4'd0; ad1 = 4'd0; e0 = 16'd0; e1 = 16'd0; esel = 1'b1;
    if (op < 4'd8) begin
      if (rs != 4'd0) begin e0 = rf[rs]; ad0 = rs; nrd = 1; end
      if (rt != 4'd0) begin
        e1 = rf[rt];
        if (nrd == 0) ad0 = rt; else ad1 = rt;
        nrd = nrd + 1;
      end
    end else if (op < 4'd12) begin
      esel = 1'b0;
      if (ra != 4'd0) begin e0 = rf[ra]; ad0 = ra; nrd = 1; end
    end
    evld = 1 + nrd * (lat + 1);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one instruction into dut1, record reads and the ALU bundle, stall `stall` cycles.
  task automatic run1(input logic [15:0] ins, input int stall);
    int  k;
    bit  done;
    nre = 0; vld_cyc = -1; stable_bad = 0; addr_bad = 0; done = 1'b0;
    k = 0;
    while (instr_rdy1 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    instr1 = ins; instr_vld1 = 1'b1;
    @(posedge clk); #1;
    instr_vld1 = 1'b0; instr1 = 16'($urandom);
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (rf_re1 === 1'b1) begin
        if (nre < 4) begin re_addr[nre] = rf_addr1; re_cyc[nre] = c; end
        nre++;
      end else if (rf_addr1 !== 4'd0) addr_bad++;
      if (alu_vld1 === 1'b1) begin
        vld_cyc = c;
        b_src0 = src0_1; b_src1 = src1_1; b_imm = imm1; b_sel = src_sel1; b_op = alu_op1;
        alu_rdy1 = (stall == 0);
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          if ({alu_vld1, src0_1, src1_1, imm1, src_sel1, alu_op1} !==
              {1'b1, b_src0, b_src1, b_imm, b_sel, b_op} || rf_re1 !== 1'b0 || instr_rdy1 !== 1'b0)
            stable_bad++;
          if (s == stall - 1) alu_rdy1 = 1'b1;
        end
        @(negedge clk);
        post_vld = alu_vld1; post_rdy = instr_rdy1; post_halt = halted1;
        alu_rdy1 = 1'b0;
        done = 1'b1;
      end else begin
        alu_rdy1 = 1'($urandom % 2);
      end
    end
    alu_rdy1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++; if (instr_rdy1 !== 1'b1) begin err_cnt++; $display("FAIL rst_instr_rdy got %b exp 1", instr_rdy1); end
    cmp_cnt++; if (alu_vld1 !== 1'b0) begin err_cnt++; $display("FAIL rst_alu_vld got %b exp 0", alu_vld1); end
    cmp_cnt++; if (rf_re1 !== 1'b0) begin err_cnt++; $display("FAIL rst_rf_re got %b exp 0", rf_re1); end
    cmp_cnt++; if (halted1 !== 1'b0) begin err_cnt++; $display("FAIL rst_halted got %b exp 0", halted1); end
    cmp_cnt++; if ({src0_1, src1_1} !== 32'd0) begin err_cnt++; $display("FAIL rst_src got %h/%h exp 0/0", src0_1, src1_1); end
    cmp_cnt++; if (instr_rdy3 !== 1'b1) begin err_cnt++; $display("FAIL rst_instr_rdy3 got %b exp 1", instr_rdy3); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    rf[2] = 16'h1111; rf[3] = 16'h2222;
    run1(16'h0123, 0);
    cmp_cnt++; if (nre !== 2) begin err_cnt++; $display("FAIL add_nreads got %0d exp 2", nre); end
    cmp_cnt++; if (re_cyc[0] !== 1 || re_addr[0] !== 4'd2) begin err_cnt++; $display("FAIL add_read0 got c%0d a%0d exp c1 a2", re_cyc[0], re_addr[0]); end
    cmp_cnt++; if (re_cyc[1] !== 3 || re_addr[1] !== 4'd3) begin err_cnt++; $display("FAIL add_read1 got c%0d a%0d exp c3 a3", re_cyc[1], re_addr[1]); end
    cmp_cnt++; if (vld_cyc !== 5) begin err_cnt++; $display("FAIL add_vld_cyc got %0d exp 5", vld_cyc); end
    cmp_cnt++; if ({b_src0, b_src1, b_sel, b_op} !== {16'h1111, 16'h2222, 1'b1, 4'h0}) begin
      err_cnt++; $display("FAIL add_bundle got %h %h %b %h exp 1111 2222 1 0", b_src0, b_src1, b_sel, b_op); end
  endtask

  task automatic test_lw();
    rf[5] = 16'h0040;
    run1(16'h85F0, 0);
    cmp_cnt++; if (nre !== 1 || re_addr[0] !== 4'd5 || re_cyc[0] !== 1) begin
      err_cnt++; $display("FAIL lw_read got n%0d a%0d c%0d exp n1 a5 c1", nre, re_addr[0], re_cyc[0]); end
    cmp_cnt++; if (vld_cyc !== 3) begin err_cnt++; $display("FAIL lw_vld_cyc got %0d exp 3", vld_cyc); end
    cmp_cnt++; if ({b_src0, b_imm, b_sel, b_op} !== {16'h0040, 8'hF0, 1'b0, 4'h8}) begin
      err_cnt++; $display("FAIL lw_bundle got %h %h %b %h exp 0040 f0 0 8", b_src0, b_imm, b_sel, b_op); end
  endtask

  task automatic test_backpressure();
    rf[4] = 16'hA5A5; rf[6] = 16'h5A5A;
    run1(16'h2146, 4);
    cmp_cnt++; if (vld_cyc !== 5) begin err_cnt++; $display("FAIL bp_vld_cyc got %0d exp 5", vld_cyc); end
    cmp_cnt++; if (stable_bad !== 0) begin err_cnt++; $display("FAIL bp_stable got %0d unstable cycles exp 0", stable_bad); end
    cmp_cnt++; if (post_vld !== 1'b0 || post_rdy !== 1'b1) begin
      err_cnt++; $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", post_vld, post_rdy); end
    cmp_cnt++; if ({b_src0, b_src1} !== {16'hA5A5, 16'h5A5A}) begin
      err_cnt++; $display("FAIL bp_operands got %h %h exp a5a5 5a5a", b_src0, b_src1); end
  endtask

  task automatic test_r0_skip();
    rf[0] = 16'h7777;
    run1(16'h0200, 0);
    cmp_cnt++; if (nre !== 0) begin err_cnt++; $display("FAIL r0_nreads got %0d exp 0", nre); end
    cmp_cnt++; if (vld_cyc !== 1) begin err_cnt++; $display("FAIL r0_vld_cyc got %0d exp 1", vld_cyc); end
    cmp_cnt++; if ({b_src0, b_src1} !== 32'd0) begin err_cnt++; $display("FAIL r0_src got %h %h exp 0 0", b_src0, b_src1); end
  endtask

  task automatic test_back_to_back_random();
    logic [15:0] ins, e0, e1;
    logic [3:0]  ad0, ad1;
    logic        esel;
    int          nrd, evld, stall;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 16; r++) rf[r] = 16'($urandom);
      ins = 16'($urandom);
      if (ins[15:12] == 4'hF) ins[15:12] = 4'hE;
      if ($urandom % 4 == 0) ins[7:4] = 4'd0;
      if ($urandom % 4 == 0) ins[3:0] = 4'd0;
      if ($urandom % 4 == 0) ins[11:8] = 4'd0;
      stall = int'($urandom % 3);
      model(ins, 1, nrd, ad0, ad1, e0, e1, esel, evld);
      run1(ins, stall);
      cmp_cnt++; if (nre !== nrd) begin err_cnt++; $display("FAIL rnd_nreads ins=%h got %0d exp %0d", ins, nre, nrd); end
      if (nrd > 0) begin
        cmp_cnt++; if (re_addr[0] !== ad0 || re_cyc[0] !== 1) begin
          err_cnt++; $display("FAIL rnd_read0 ins=%h got a%0d c%0d exp a%0d c1", ins, re_addr[0], re_cyc[0], ad0); end
      end
      if (nrd > 1) begin
        cmp_cnt++; if (re_addr[1] !== ad1 || re_cyc[1] !== 3) begin
          err_cnt++; $display("FAIL rnd_read1 ins=%h got a%0d c%0d exp a%0d c3", ins, re_addr[1], re_cyc[1], ad1); end
      end
      cmp_cnt++; if (vld_cyc !== evld) begin err_cnt++; $display("FAIL rnd_vld_cyc ins=%h got %0d exp %0d", ins, vld_cyc, evld); end
      cmp_cnt++; if ({b_src0, b_sel, b_imm, b_op} !== {e0, esel, ins[7:0], ins[15:12]}) begin
        err_cnt++; $display("FAIL rnd_bundle ins=%h got %h %b %h %h exp %h %b %h %h", ins, b_src0, b_sel, b_imm, b_op, e0, esel, ins[7:0], ins[15:12]); end
      if (esel) begin
        cmp_cnt++; if (b_src1 !== e1) begin err_cnt++; $display("FAIL rnd_src1 ins=%h got %h exp %h", ins, b_src1, e1); end
      end
      cmp_cnt++; if (stable_bad !== 0 || addr_bad !== 0 || post_vld !== 1'b0 || post_rdy !== 1'b1) begin
        err_cnt++; $display("FAIL rnd_protocol ins=%h got stable=%0d addr=%0d vld=%b rdy=%b exp 0 0 0 1", ins, stable_bad, addr_bad, post_vld, post_rdy); end
    end
  endtask

  task automatic test_lat3();
    int nr, vc, rc0, rc1, k;
    bit done;
    rf[2] = 16'h3C3C; rf[3] = 16'hC3C3;
    nr = 0; vc = -1; rc0 = -1; rc1 = -1; done = 1'b0; k = 0;
    while (instr_rdy3 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    instr3 = 16'h0123; instr_vld3 = 1'b1;
    @(posedge clk); #1;
    instr_vld3 = 1'b0;
    for (int c = 1; c <= 30 && !done; c++) begin
      @(negedge clk);
      if (rf_re3 === 1'b1) begin
        if (nr == 0) rc0 = c; else rc1 = c;
        nr++;
      end
      if (alu_vld3 === 1'b1) begin
        vc = c;
        cmp_cnt++; if ({src0_3, src1_3} !== {16'h3C3C, 16'hC3C3}) begin
          err_cnt++; $display("FAIL lat3_operands got %h %h exp 3c3c c3c3", src0_3, src1_3); end
        alu_rdy3 = 1'b1;
        @(negedge clk);
        alu_rdy3 = 1'b0;
        done = 1'b1;
      end
    end
    cmp_cnt++; if (vc !== 9) begin err_cnt++; $display("FAIL lat3_vld_cyc got %0d exp 9", vc); end
    cmp_cnt++; if (nr !== 2 || rc0 !== 1 || rc1 !== 5) begin
      err_cnt++; $display("FAIL lat3_reads got n%0d c%0d c%0d exp n2 c1 c5", nr, rc0, rc1); end
  endtask

  task automatic test_hlt();
    int bad;
    run1(16'hF000, 1);
    cmp_cnt++; if (vld_cyc !== 1 || nre !== 0) begin err_cnt++; $display("FAIL hlt_issue got c%0d n%0d exp c1 n0", vld_cyc, nre); end
    cmp_cnt++; if (post_halt !== 1'b1 || post_rdy !== 1'b0) begin
      err_cnt++; $display("FAIL hlt_state got halted=%b rdy=%b exp 1 0", post_halt, post_rdy); end
    instr1 = 16'h0123; instr_vld1 = 1'b1; bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (instr_rdy1 !== 1'b0 || halted1 !== 1'b1 || rf_re1 !== 1'b0 || alu_vld1 !== 1'b0) bad++;
    end
    instr_vld1 = 1'b0;
    cmp_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL hlt_sticky got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int bad;
    do_reset();
    rf[2] = 16'h0F0F; rf[3] = 16'hF0F0;
    instr1 = 16'h0123; instr_vld1 = 1'b1;
    @(posedge clk); #1;
    instr_vld1 = 1'b0;
    found = 1'b0;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge clk);
      if (rf_re1 === 1'b1 && rf_addr1 === 4'd3) found = 1'b1;
    end
    cmp_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL rmid_reach_rdb got %b exp 1", found); end
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++; if ({rf_re1, alu_vld1, instr_rdy1, halted1} !== 4'b0010) begin
      err_cnt++; $display("FAIL rmid_async got re=%b vld=%b rdy=%b halt=%b exp 0 0 1 0", rf_re1, alu_vld1, instr_rdy1, halted1); end
    @(negedge clk);
    rst_n = 1'b1; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (alu_vld1 !== 1'b0 || rf_re1 !== 1'b0 || instr_rdy1 !== 1'b1) bad++;
    end
    cmp_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL rmid_idle got %0d bad cycles exp 0", bad); end
  endtask

  initial begin
    instr_vld1 = 1'b0; instr1 = 16'd0; alu_rdy1 = 1'b0;
    instr_vld3 = 1'b0; instr3 = 16'd0; alu_rdy3 = 1'b0;
    for (int r = 0; r < 16; r++) rf[r] = 16'd0;
    test_reset();
    test_add();
    test_lw();
    test_backpressure();
    test_r0_skip();
    test_back_to_back_random();
    test_lat3();
    test_hlt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
